// File: rtl/socket_frame_packer.sv
//==============================================================================
// Module      : socket_frame_packer
// Description : Collects FRAME_LEN upstream words into a buffer, then streams
//               them out as one valid/ready frame with a last-word marker.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module socket_frame_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int FRAME_LEN  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_dv,
  output logic                  o_idle,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_last,
  output logic                  o_overflow,
  output logic [CNT_WIDTH-1:0]  o_frame_cnt
);

  localparam int IDX_W = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(FRAME_LEN - 1);

  typedef enum logic [0:0] {
    ST_COLLECT = 1'b0,
    ST_SEND    = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DATA_WIDTH-1:0] r_buf [FRAME_LEN];
  logic [IDX_W-1:0]      r_wr_idx;
  logic [IDX_W-1:0]      r_rd_idx;
  logic                  r_overflow;
  logic [CNT_WIDTH-1:0]  r_frame_cnt;
  logic                  w_wr_en;
  logic                  w_xfer;
  logic                  w_last;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_COLLECT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_idle      = 1'b1;
    o_valid     = 1'b0;
    w_last      = 1'b0;
    w_wr_en     = 1'b0;
    w_xfer      = 1'b0;
    case (r_state)
      ST_COLLECT: begin
        w_wr_en = i_dv;
        if (i_dv && (r_wr_idx == c_last_idx)) begin
          w_state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        o_idle  = 1'b0;
        o_valid = 1'b1;
        w_last  = (r_rd_idx == c_last_idx);
        w_xfer  = i_ready;
        if (i_ready && w_last) begin
          w_state_nxt = ST_COLLECT;
        end
      end
      default: w_state_nxt = ST_COLLECT;
    endcase
  end

  // Buffer contents survive reset; the indices alone define what is valid.
  always_ff @(posedge i_clk) begin
    if (w_wr_en) begin
      r_buf[r_wr_idx] <= i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_idx    <= '0;
      r_rd_idx    <= '0;
      r_overflow  <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      if (w_wr_en) begin
        if (r_wr_idx == c_last_idx) begin
          r_wr_idx <= '0;
          r_rd_idx <= '0;
        end else begin
          r_wr_idx <= r_wr_idx + 1'b1;
        end
      end
      // A word seen while sending, including on the final transfer edge, is lost.
      if ((r_state == ST_SEND) && i_dv) begin
        r_overflow <= 1'b1;
      end
      if (w_xfer) begin
        if (w_last) begin
          r_rd_idx    <= '0;
          r_frame_cnt <= r_frame_cnt + 1'b1;
        end else begin
          r_rd_idx <= r_rd_idx + 1'b1;
        end
      end
    end
  end

  assign o_data      = r_buf[r_rd_idx];
  assign o_last      = w_last;
  assign o_overflow  = r_overflow;
  assign o_frame_cnt = r_frame_cnt;

endmodule

`default_nettype wire

// File: tb/tb_socket_frame_packer.sv
//==============================================================================
// Module      : tb_socket_frame_packer
// Description : Scoreboard bench for socket_frame_packer (FRAME_LEN 4, 2-bit
//               frame counter so counter wrap is reachable).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_socket_frame_packer;

  localparam int DATA_WIDTH = 8;
  localparam int FRAME_LEN  = 4;
  localparam int CNT_WIDTH  = 2;

  logic                  clk;
  logic                  rst_n;
  logic [DATA_WIDTH-1:0] i_data;
  logic                  i_dv;
  logic                  o_idle;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_valid;
  logic                  i_ready;
  logic                  o_last;
  logic                  o_overflow;
  logic [CNT_WIDTH-1:0]  o_frame_cnt;

  socket_frame_packer #(
    .DATA_WIDTH(DATA_WIDTH),
    .FRAME_LEN (FRAME_LEN),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_data     (i_data),
    .i_dv       (i_dv),
    .o_idle     (o_idle),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_last     (o_last),
    .o_overflow (o_overflow),
    .o_frame_cnt(o_frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Scoreboard entries: {last, data}
  logic [DATA_WIDTH:0]  exp_q[$];
  logic [CNT_WIDTH-1:0] exp_cnt = '0;
  logic                 exp_ovf = 1'b0;
  logic                 prev_stall = 1'b0;
  logic [DATA_WIDTH-1:0] prev_data = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [DATA_WIDTH:0] e;
    if (!rst_n) begin
      exp_cnt    = '0;
      prev_stall = 1'b0;
      check("rst_idle", 32'(o_idle), 32'd1);
      check("rst_valid", 32'(o_valid), 32'd0);
      check("rst_last", 32'(o_last), 32'd0);
    end else begin
      check("idle", 32'(o_idle), 32'(!o_valid));
      check("overflow", 32'(o_overflow), 32'(exp_ovf));
      check("frame_cnt", 32'(o_frame_cnt), 32'(exp_cnt));
      if (prev_stall) begin
        check("hold_valid", 32'(o_valid), 32'd1);
        check("hold_data", 32'(o_data), 32'(prev_data));
      end
      if (o_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 32'(o_data), 32'hFFFF_FFFF);
        end else if (i_ready) begin
          e = exp_q.pop_front();
          check("out_data", 32'(o_data), 32'(e[DATA_WIDTH-1:0]));
          check("out_last", 32'(o_last), 32'(e[DATA_WIDTH]));
          if (e[DATA_WIDTH]) exp_cnt = exp_cnt + 1'b1;
        end
      end else begin
        check("last_when_idle", 32'(o_last), 32'd0);
      end
      prev_stall = o_valid && !i_ready;
      prev_data  = o_data;
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the last word's write edge.
  task automatic send_frame(input logic [31:0] words, input int gap);
    for (int i = 0; i < FRAME_LEN; i++) begin
      i_data = words[31-8*i -: 8];
      i_dv   = 1'b1;
      if (i == FRAME_LEN - 1) begin
        for (int j = 0; j < FRAME_LEN; j++) begin
          exp_q.push_back({(j == FRAME_LEN - 1), words[31-8*j -: 8]});
        end
      end
      @(posedge clk); #1;
      i_dv = 1'b0;
      if (i != FRAME_LEN - 1) begin
        repeat (gap) begin
          @(posedge clk); #1;
        end
      end
    end
    check("latency_valid", 32'(o_valid), 32'd1);
    check("latency_word0", 32'(o_data), 32'(words[31:24]));
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check("async_rst_idle", 32'(o_idle), 32'd1);
    check("async_rst_valid", 32'(o_valid), 32'd0);
    check("async_rst_ovf", 32'(o_overflow), 32'd0);
    check("async_rst_cnt", 32'(o_frame_cnt), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    exp_ovf = 1'b0;
    rst_n   = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [CNT_WIDTH-1:0] wrap_seq [5];
    wrap_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    rst_n   = 1'b0;
    i_dv    = 1'b0;
    i_data  = '0;
    i_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic frame
    send_frame(32'h11223344, 0);
    wait_drain();
    check("basic_cnt", 32'(o_frame_cnt), 32'd1);
    check("basic_ovf", 32'(o_overflow), 32'd0);

    // Backpressure on word 1
    send_frame(32'h11223344, 0);
    @(posedge clk); #1;
    i_ready = 1'b0;
    check("bp_data", 32'(o_data), 32'h22);
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("bp_data_held", 32'(o_data), 32'h22);
    i_ready = 1'b1;
    wait_drain();
    check("bp_cnt", 32'(o_frame_cnt), 32'd2);

    // Gapped input
    send_frame(32'hA0A1A2A3, 2);
    wait_drain();

    // Word arriving on the last-transfer edge is dropped
    apply_reset();
    send_frame(32'hC0C1C2C3, 0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    i_data = 8'h77;
    i_dv   = 1'b1;
    @(posedge clk); #1;
    i_dv    = 1'b0;
    exp_ovf = 1'b1;
    check("same_edge_ovf", 32'(o_overflow), 32'd1);
    wait_drain();
    send_frame(32'hD0D1D2D3, 1);
    wait_drain();

    // Overflow while stalled, sticky through the next frame
    apply_reset();
    i_ready = 1'b0;
    send_frame(32'h61626364, 0);
    i_data = 8'h55;
    i_dv   = 1'b1;
    @(posedge clk); #1;
    i_dv    = 1'b0;
    exp_ovf = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    i_ready = 1'b1;
    wait_drain();
    send_frame(32'h71727374, 0);
    wait_drain();
    check("ovf_sticky", 32'(o_overflow), 32'd1);

    // Reset mid-collect
    i_data = 8'hE0; i_dv = 1'b1;
    @(posedge clk); #1;
    i_data = 8'hE1;
    @(posedge clk); #1;
    i_dv = 1'b0;
    apply_reset();
    send_frame(32'h01020304, 0);
    wait_drain();
    check("rst_mid_cnt", 32'(o_frame_cnt), 32'd1);
    check("rst_mid_ovf", 32'(o_overflow), 32'd0);

    // Reset mid-send
    i_ready = 1'b0;
    send_frame(32'hF0F1F2F3, 0);
    i_ready = 1'b1;
    apply_reset();
    send_frame(32'h05060708, 3);
    wait_drain();
    check("rst_send_cnt", 32'(o_frame_cnt), 32'd1);

    // Counter wrap with a 2-bit counter
    apply_reset();
    for (int f = 0; f < 5; f++) begin
      send_frame({8'(f), 8'(f + 16), 8'(f + 32), 8'(f + 48)}, f % 2);
      wait_drain();
      check("wrap_cnt", 32'(o_frame_cnt), 32'(wrap_seq[f]));
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
